sha256_3_to_1_reorderer: RTL and testbench

Collects 256-bit digests from the three parallel SHA-256 hash engines and returns them on a single output stream in strict packet-ID order. It sits downstream of the engines and mirrors the 1-to-3 input dispatcher, undoing the out-of-order completion caused by distributing packets across engines. A single registered output slot gives full throughput with one-cycle latency. An optional watchdog skips packet IDs that never arrive.

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_reorder_match.sv | 42 ++++
 rtl/sha256_3_to_1_reorderer.sv | 159 +++++++++++++++
 tb/tb_sha256_3_to_1_reorderer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared widths, types and defaults for the SHA-256 engine reorder path.
package sha256_pkg;

    localparam int unsigned SHA256_DATA_W     = 256;
    localparam int unsigned SHA256_ID_W       = 5;
    localparam int unsigned SHA256_WDOG_LIMIT = 1024;

    typedef logic [SHA256_DATA_W-1:0] digest_t;
    typedef logic [SHA256_ID_W-1:0]   packet_id_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/sha256_reorder_match.sv
// Compares each engine's packet ID against the expected ID and picks the
// lowest-numbered matching engine; flags when more than one engine matches.
module sha256_reorder_match
    import sha256_pkg::*;
#(
    parameter int unsigned ID_W = SHA256_ID_W
) (
    input  logic [2:0]      valid_i,
    input  logic [ID_W-1:0] id0_i,
    input  logic [ID_W-1:0] id1_i,
    input  logic [ID_W-1:0] id2_i,
    input  logic [ID_W-1:0] expected_id_i,
    output logic [2:0]      grant_o,
    output logic [1:0]      sel_o,
    output logic            any_match_o,
    output logic            collision_o
);

    logic [2:0] match;

    assign match[0] = valid_i[0] & (id0_i == expected_id_i);
    assign match[1] = valid_i[1] & (id1_i == expected_id_i);
    assign match[2] = valid_i[2] & (id2_i == expected_id_i);

    always_comb begin
        grant_o = '0;
        sel_o   = '0;
        if (match[0]) begin
            grant_o = 3'b001;
        end else if (match[1]) begin
            grant_o = 3'b010;
            sel_o   = 2'd1;
        end else if (match[2]) begin
            grant_o = 3'b100;
            sel_o   = 2'd2;
        end
    end

    assign any_match_o = |match;
    assign collision_o = (match[0] & match[1]) | (match[0] & match[2]) | (match[1] & match[2]);

endmodule

// File: rtl/sha256_3_to_1_reorderer.sv
// Merges digests from three SHA-256 engines into one stream in packet-ID order.
// Define SHA256_REORDER_WATCHDOG_EN to skip IDs that stall for WDOG_LIMIT cycles.
module sha256_3_to_1_reorderer
    import sha256_pkg::*;
#(
    parameter int unsigned DATA_W = SHA256_DATA_W,
    parameter int unsigned ID_W   = SHA256_ID_W
`ifdef SHA256_REORDER_WATCHDOG_EN
   ,parameter int unsigned WDOG_LIMIT = SHA256_WDOG_LIMIT
`endif
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic              sync_rst,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic [ID_W-1:0]   data_in_packet_id_0,
    input  logic              data_in_valid_0,
    output logic              data_in_ready_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic [ID_W-1:0]   data_in_packet_id_1,
    input  logic              data_in_valid_1,
    output logic              data_in_ready_1,
    input  logic [DATA_W-1:0] data_in_2,
    input  logic [ID_W-1:0]   data_in_packet_id_2,
    input  logic              data_in_valid_2,
    output logic              data_in_ready_2,
    output logic [DATA_W-1:0] data_out,
    output logic [ID_W-1:0]   data_out_packet_id,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              err_collision,
    output logic              err_timeout
);

    slot_state_t       slot_q, slot_d;
    logic [DATA_W-1:0] data_q, data_d, sel_data;
    logic [ID_W-1:0]   id_q, id_d, exp_id_q, exp_id_d;
    logic              coll_q, coll_d;
    logic [2:0]        grant, valid_vec;
    logic [1:0]        sel;
    logic              any_match, collision, slot_free, accept_ok, take;

    assign valid_vec = {data_in_valid_2, data_in_valid_1, data_in_valid_0};

    sha256_reorder_match #(.ID_W(ID_W)) u_match (
        .valid_i       (valid_vec),
        .id0_i         (data_in_packet_id_0),
        .id1_i         (data_in_packet_id_1),
        .id2_i         (data_in_packet_id_2),
        .expected_id_i (exp_id_q),
        .grant_o       (grant),
        .sel_o         (sel),
        .any_match_o   (any_match),
        .collision_o   (collision)
    );

    assign slot_free = (slot_q == SLOT_EMPTY) | data_out_ready;
    assign accept_ok = en & ~sync_rst & slot_free;
    assign take      = accept_ok & any_match;

    assign data_in_ready_0 = accept_ok & grant[0];
    assign data_in_ready_1 = accept_ok & grant[1];
    assign data_in_ready_2 = accept_ok & grant[2];

    always_comb begin
        case (sel)
            2'd1:    sel_data = data_in_1;
            2'd2:    sel_data = data_in_2;
            default: sel_data = data_in_0;
        endcase
    end

`ifdef SHA256_REORDER_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              tmo_q, tmo_d;
    assign err_timeout = tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        slot_d   = slot_q;
        data_d   = data_q;
        id_d     = id_q;
        exp_id_d = exp_id_q;
        coll_d   = 1'b0;
`ifdef SHA256_REORDER_WATCHDOG_EN
        wdog_d   = wdog_q;
        tmo_d    = 1'b0;
`endif
        if (take) begin
            slot_d   = SLOT_FULL;
            data_d   = sel_data;
            id_d     = exp_id_q;
            exp_id_d = exp_id_q + 1'b1;
            coll_d   = collision;
`ifdef SHA256_REORDER_WATCHDOG_EN
            wdog_d   = '0;
`endif
        end else begin
            if (data_out_ready) slot_d = SLOT_EMPTY;
`ifdef SHA256_REORDER_WATCHDOG_EN
            // Stall counts only while the slot could have taken the missing ID.
            if (slot_free && (|valid_vec) && !any_match) begin
                if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
                    wdog_d   = '0;
                    exp_id_d = exp_id_q + 1'b1;
                    tmo_d    = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
`endif
        end
        if (sync_rst) begin
            slot_d   = SLOT_EMPTY;
            data_d   = '0;
            id_d     = '0;
            exp_id_d = '0;
            coll_d   = 1'b0;
`ifdef SHA256_REORDER_WATCHDOG_EN
            wdog_d   = '0;
            tmo_d    = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slot_q   <= SLOT_EMPTY;
            data_q   <= '0;
            id_q     <= '0;
            exp_id_q <= '0;
            coll_q   <= 1'b0;
`ifdef SHA256_REORDER_WATCHDOG_EN
            wdog_q   <= '0;
            tmo_q    <= 1'b0;
`endif
        end else if (en || sync_rst) begin
            slot_q   <= slot_d;
            data_q   <= data_d;
            id_q     <= id_d;
            exp_id_q <= exp_id_d;
            coll_q   <= coll_d;
`ifdef SHA256_REORDER_WATCHDOG_EN
            wdog_q   <= wdog_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign data_out           = data_q;
    assign data_out_packet_id = id_q;
    assign data_out_valid     = (slot_q == SLOT_FULL);
    assign err_collision      = coll_q;

endmodule

// File: tb/tb_sha256_3_to_1_reorderer.sv
// Directed bench for sha256_3_to_1_reorderer; covers the watchdog path when
// SHA256_REORDER_WATCHDOG_EN is defined (WDOG_LIMIT overridden to 8).
module tb_sha256_3_to_1_reorderer;
    import sha256_pkg::*;

    localparam int unsigned DW = SHA256_DATA_W;

    logic       clk = 1'b0;
    logic       nrst, en, sync_rst, data_out_ready;
    digest_t    din [3];
    packet_id_t pid [3];
    logic [2:0] vin, rdy;
    digest_t    data_out;
    packet_id_t data_out_packet_id;
    logic       data_out_valid, err_collision, err_timeout;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    sha256_3_to_1_reorderer #(
        .DATA_W     (SHA256_DATA_W),
        .ID_W       (SHA256_ID_W)
`ifdef SHA256_REORDER_WATCHDOG_EN
       ,.WDOG_LIMIT (8)
`endif
    ) dut (
        .clk                 (clk),
        .nrst                (nrst),
        .en                  (en),
        .sync_rst            (sync_rst),
        .data_in_0           (din[0]),
        .data_in_packet_id_0 (pid[0]),
        .data_in_valid_0     (vin[0]),
        .data_in_ready_0     (rdy[0]),
        .data_in_1           (din[1]),
        .data_in_packet_id_1 (pid[1]),
        .data_in_valid_1     (vin[1]),
        .data_in_ready_1     (rdy[1]),
        .data_in_2           (din[2]),
        .data_in_packet_id_2 (pid[2]),
        .data_in_valid_2     (vin[2]),
        .data_in_ready_2     (rdy[2]),
        .data_out            (data_out),
        .data_out_packet_id  (data_out_packet_id),
        .data_out_valid      (data_out_valid),
        .data_out_ready      (data_out_ready),
        .err_collision       (err_collision),
        .err_timeout         (err_timeout)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic digest_t dig(input int unsigned id, input int unsigned k);
        logic [31:0] w;
        w = 32'hC0DE0000 | (k << 8) | id;
        return {8{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input int unsigned k, input int unsigned id, input digest_t d);
        vin[k] = 1'b1;
        pid[k] = packet_id_t'(id);
        din[k] = d;
    endtask

    task automatic check_out(input string tag, input int unsigned id, input digest_t d);
        check({tag, "_valid"}, data_out_valid, 1'b1);
        check({tag, "_id"}, data_out_packet_id, packet_id_t'(id));
        check({tag, "_data"}, data_out, d);
    endtask

    task automatic do_sync_rst();
        vin      = '0;
        sync_rst = 1'b1;
        settle();
        check("srst_rdy", rdy, 3'b000);
        tick();
        sync_rst = 1'b0;
        check("srst_valid", data_out_valid, 1'b0);
        check("srst_id", data_out_packet_id, '0);
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; sync_rst = 1'b0; data_out_ready = 1'b1;
        vin = '0;
        for (int k = 0; k < 3; k++) begin
            din[k] = '0;
            pid[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", data_out_valid, 1'b0);
        check("rst_data", data_out, '0);
        check("rst_id", data_out_packet_id, '0);
        check("rst_coll", err_collision, 1'b0);
        check("rst_tmo", err_timeout, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // In order on engine 0: one output per cycle, one-cycle latency.
        for (int i = 0; i < 3; i++) begin
            present(0, i, dig(i, 0));
            settle();
            check($sformatf("inord_rdy%0d", i), rdy, 3'b001);
            tick();
            check_out($sformatf("inord%0d", i), i, dig(i, 0));
        end
        vin = '0;
        tick();
        check("inord_empty", data_out_valid, 1'b0);

        // Out of order: ID 1 waits on engine 1 until ID 0 shows up on engine 0.
        do_sync_rst();
        present(1, 1, dig(1, 1));
        for (int c = 0; c < 3; c++) begin
            settle();
            check($sformatf("ooo_stall%0d", c), rdy, 3'b000);
            tick();
            check($sformatf("ooo_nov%0d", c), data_out_valid, 1'b0);
        end
        present(0, 0, dig(0, 0));
        settle();
        check("ooo_rdy0", rdy, 3'b001);
        tick();
        check_out("ooo_out0", 0, dig(0, 0));
        vin[0] = 1'b0;
        settle();
        check("ooo_rdy1", rdy, 3'b010);
        tick();
        check_out("ooo_out1", 1, dig(1, 1));
        vin[1] = 1'b0;

        // Backpressure with slot full, then drain and accept together.
        data_out_ready = 1'b0;
        present(2, 2, dig(2, 2));
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("bp_rdy%0d", c), rdy, 3'b000);
            tick();
            check_out($sformatf("bp_hold%0d", c), 1, dig(1, 1));
        end
        data_out_ready = 1'b1;
        settle();
        check("bp_release_rdy", rdy, 3'b100);
        tick();
        check_out("bp_out2", 2, dig(2, 2));
        vin = '0;
        tick();
        check("bp_empty", data_out_valid, 1'b0);

        // Collision on ID 4 between engines 0 and 2.
        do_sync_rst();
        for (int i = 0; i < 4; i++) begin
            present(0, i, dig(i, 0));
            tick();
        end
        present(0, 4, dig(4, 0));
        present(2, 4, dig(4, 2));
        settle();
        check("coll_rdy", rdy, 3'b001);
        check("coll_pre", err_collision, 1'b0);
        tick();
        check_out("coll_out", 4, dig(4, 0));
        check("coll_pulse", err_collision, 1'b1);
        vin = '0;
        tick();
        check("coll_clear", err_collision, 1'b0);

        // 40 packets round-robin across engines: IDs wrap 31 -> 0.
        do_sync_rst();
        for (int i = 0; i < 40; i++) begin
            vin = '0;
            present(i % 3, i % 32, dig(i, i % 3));
            tick();
            check_out($sformatf("wrap%0d", i), i % 32, dig(i, i % 3));
        end
        vin = '0;
        tick();

        // Global enable low freezes the slot even with downstream ready.
        do_sync_rst();
        present(0, 0, dig(0, 0));
        tick();
        present(0, 1, dig(1, 0));
        en = 1'b0;
        settle();
        check("en_rdy", rdy, 3'b000);
        tick();
        tick();
        check_out("en_hold", 0, dig(0, 0));
        en = 1'b1;
        settle();
        check("en_rdy_back", rdy, 3'b001);
        tick();
        check_out("en_out1", 1, dig(1, 0));
        vin = '0;
        tick();

        // ID 3 never arrives; engine 1 holds ID 4.
        do_sync_rst();
        for (int i = 0; i < 3; i++) begin
            present(0, i, dig(i, 0));
            tick();
        end
        vin[0] = 1'b0;
        present(1, 4, dig(4, 1));
`ifdef SHA256_REORDER_WATCHDOG_EN
        for (int c = 1; c < 8; c++) begin
            tick();
            check($sformatf("wd_quiet%0d", c), err_timeout, 1'b0);
            check($sformatf("wd_stall%0d", c), rdy, 3'b000);
        end
        tick();
        check("wd_pulse", err_timeout, 1'b1);
        check("wd_rdy1", rdy, 3'b010);
        tick();
        check("wd_pulse_end", err_timeout, 1'b0);
        check_out("wd_out4", 4, dig(4, 1));
`else
        for (int c = 0; c < 100; c++) begin
            tick();
            check($sformatf("nowd_tmo%0d", c), err_timeout, 1'b0);
            check($sformatf("nowd_rdy%0d", c), rdy, 3'b000);
        end
        check("nowd_empty", data_out_valid, 1'b0);
`endif
        vin = '0;

        // Asynchronous reset mid-stream discards the slot immediately.
        do_sync_rst();
        present(0, 0, dig(0, 0));
        tick();
        vin = '0;
        data_out_ready = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        check("arst_valid", data_out_valid, 1'b0);
        check("arst_data", data_out, '0);
        @(negedge clk);
        nrst = 1'b1;
        data_out_ready = 1'b1;
        present(0, 0, dig(0, 2));
        tick();
        check_out("arst_restart", 0, dig(0, 2));
        vin = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
